disc_acq_engine: RTL and testbench

DISC_ACQ_ENGINE -- requirements
Module: disc_acq_engine

---
 rtl/disc_acq_pkg.sv | 23 ++
 rtl/acq_fifo.sv | 51 +++++
 rtl/disc_acq_engine.sv | 163 ++++++++++++++++
 tb/tb_disc_acq_engine.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disc_acq_pkg.sv
// Shared definitions for the disc acquisition engine: FSM states and
// word-format helpers derived from the output width.
package disc_acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_ACQ,
    ST_DRAIN,
    ST_DONE
  } acq_state_e;

  // Largest count value carried in a normal word (all-ones is reserved for overflow).
  function automatic int unsigned max_count(input int unsigned bits);
    return (32'd1 << (bits - 32'd1)) - 32'd2;
  endfunction

  // Overflow marker word: index flag 0, count field all ones.
  function automatic int unsigned ovf_word(input int unsigned bits);
    return (32'd1 << (bits - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/acq_fifo.sv
// Show-ahead FIFO: the head word is visible on rdata_o whenever not empty,
// and reads as zero when empty.
module acq_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/disc_acq_engine.sv
// Disc flux acquisition: times rddata/index edges with a gated counter and
// streams {index flag, count} words to RAM through a show-ahead FIFO.
module disc_acq_engine
  import disc_acq_pkg::*;
#(
  parameter int unsigned BITS       = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned STOPW      = 8
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             CLKEN,
  input  logic             START,
  input  logic             ABORT,
  input  logic             WAIT_INDEX,
  input  logic [STOPW-1:0] INDEX_STOP_COUNT,
  input  logic             FD_RDDATA_IN,
  input  logic             FD_INDEX_IN,
  input  logic             RAM_READY,
  output logic [BITS-1:0]  DATA,
  output logic             WRITE,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVERRUN
);

  localparam int unsigned     CW       = BITS - 1;
  localparam logic [CW-1:0]   CNT_MAX  = CW'(max_count(BITS));
  localparam logic [BITS-1:0] OVF_WORD = BITS'(ovf_word(BITS));

  logic [1:0]       rd_sync_q, idx_sync_q;
  logic             rd_prev_q, idx_prev_q, idx_pulse_prev_q;
  logic             rd_pulse, idx_pulse, event_p, idx_flag, stop_hit;
  acq_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [STOPW-1:0] idx_cnt_q, idx_cnt_d, idx_cnt_inc, stop_q;
  logic             wait_idx_q, ovr_q, arm;
  logic             push, pop, fifo_full, fifo_empty;
  logic [BITS-1:0]  push_data;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_sync_q        <= '0;
      idx_sync_q       <= '0;
      rd_prev_q        <= 1'b0;
      idx_prev_q       <= 1'b0;
      idx_pulse_prev_q <= 1'b0;
    end else begin
      rd_sync_q        <= {rd_sync_q[0], FD_RDDATA_IN};
      idx_sync_q       <= {idx_sync_q[0], FD_INDEX_IN};
      rd_prev_q        <= rd_sync_q[1];
      idx_prev_q       <= idx_sync_q[1];
      idx_pulse_prev_q <= idx_pulse;
    end
  end

  assign rd_pulse    = rd_sync_q[1] & ~rd_prev_q;
  assign idx_pulse   = idx_sync_q[1] & ~idx_prev_q;
  assign event_p     = rd_pulse | idx_pulse;
  assign idx_flag    = idx_pulse | idx_pulse_prev_q;
  assign idx_cnt_inc = idx_cnt_q + STOPW'(1);
  assign stop_hit    = idx_pulse && (stop_q != '0) && (idx_cnt_inc == stop_q);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (START) state_d = ST_ARM;
      ST_ARM: begin
        if (ABORT)                          state_d = ST_DRAIN;
        else if (!wait_idx_q || idx_pulse)  state_d = ST_ACQ;
      end
      ST_ACQ:   if (ABORT || stop_hit) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY      = 1'b0;
    DONE      = 1'b0;
    arm       = 1'b0;
    push      = 1'b0;
    push_data = '0;
    cnt_d     = cnt_q;
    idx_cnt_d = idx_cnt_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        DONE = (state_q == ST_DONE);
        if (START) begin
          arm       = 1'b1;
          cnt_d     = '0;
          idx_cnt_d = '0;
        end
      end
      ST_ARM, ST_DRAIN: BUSY = 1'b1;
      ST_ACQ: begin
        BUSY = 1'b1;
        // Abort suppresses any word this cycle; an edge outranks overflow.
        if (!ABORT) begin
          if (event_p) begin
            push      = 1'b1;
            push_data = {idx_flag, cnt_q};
            cnt_d     = '0;
            if (idx_pulse) idx_cnt_d = idx_cnt_inc;
          end else if (CLKEN) begin
            if (cnt_q == CNT_MAX) begin
              push      = 1'b1;
              push_data = OVF_WORD;
              cnt_d     = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q      <= '0;
      idx_cnt_q  <= '0;
      stop_q     <= '0;
      wait_idx_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_cnt_q <= idx_cnt_d;
      if (arm) begin
        stop_q     <= INDEX_STOP_COUNT;
        wait_idx_q <= WAIT_INDEX;
        ovr_q      <= 1'b0;
      end else if (push && fifo_full && !pop) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign WRITE   = !fifo_empty;
  assign pop     = WRITE && RAM_READY;
  assign OVERRUN = ovr_q;

  acq_fifo #(
    .WIDTH (BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLOCK),
    .rst_ni  (RESET_N),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_data),
    .rdata_o (DATA),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_disc_acq_engine.sv
// Self-checking bench for disc_acq_engine: directed scenarios plus random
// traffic, compared every cycle against a behavioural word-queue model.
module tb_disc_acq_engine;

  localparam int M_IDLE  = 0;
  localparam int M_ARM   = 1;
  localparam int M_ACQ   = 2;
  localparam int M_DRAIN = 3;
  localparam int M_DONE  = 4;
  localparam int MAXC    = 32766;

  logic        CLOCK = 1'b0;
  logic        RESET_N, CLKEN, START, ABORT, WAIT_INDEX;
  logic [7:0]  INDEX_STOP_COUNT;
  logic        FD_RDDATA_IN, FD_INDEX_IN, RAM_READY;
  logic [15:0] DATA;
  logic        WRITE, BUSY, DONE, OVERRUN;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 0;

  disc_acq_engine #(
    .BITS       (16),
    .FIFO_DEPTH (16),
    .STOPW      (8)
  ) dut (
    .CLOCK            (CLOCK),
    .RESET_N          (RESET_N),
    .CLKEN            (CLKEN),
    .START            (START),
    .ABORT            (ABORT),
    .WAIT_INDEX       (WAIT_INDEX),
    .INDEX_STOP_COUNT (INDEX_STOP_COUNT),
    .FD_RDDATA_IN     (FD_RDDATA_IN),
    .FD_INDEX_IN      (FD_INDEX_IN),
    .RAM_READY        (RAM_READY),
    .DATA             (DATA),
    .WRITE            (WRITE),
    .BUSY             (BUSY),
    .DONE             (DONE),
    .OVERRUN          (OVERRUN)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference model: queue of expected words plus acquisition mode and counters.
  logic [15:0] m_q[$];
  int          m_mode = M_IDLE;
  int          m_cnt  = 0;
  int          m_icnt = 0;
  int          m_stop = 0;
  bit          m_wi   = 0;
  bit          m_ovr  = 0;
  bit          m_pidx = 0;
  bit [3:0]    rh = '0;
  bit [3:0]    ih = '0;

  always @(posedge CLOCK or negedge RESET_N) begin : model
    bit          rp, ip, pop, push;
    logic [15:0] w;
    if (!RESET_N) begin
      m_q.delete();
      m_mode = M_IDLE; m_cnt = 0; m_icnt = 0; m_stop = 0;
      m_wi = 0; m_ovr = 0; m_pidx = 0; rh = '0; ih = '0;
    end else begin
      // Edges reach the engine two clocks after the input level is first sampled.
      rh = {rh[2:0], FD_RDDATA_IN};
      ih = {ih[2:0], FD_INDEX_IN};
      rp = rh[2] & ~rh[3];
      ip = ih[2] & ~ih[3];
      pop  = (m_q.size() != 0) && RAM_READY;
      push = 0;
      w    = '0;
      case (m_mode)
        M_IDLE, M_DONE: if (START) begin
          m_mode = M_ARM; m_ovr = 0; m_wi = WAIT_INDEX;
          m_stop = int'(INDEX_STOP_COUNT); m_cnt = 0; m_icnt = 0;
        end
        M_ARM: begin
          if (ABORT) m_mode = M_DRAIN;
          else if (!m_wi || ip) m_mode = M_ACQ;
        end
        M_ACQ: begin
          if (ABORT) m_mode = M_DRAIN;
          else if (rp || ip) begin
            push = 1; w = {(ip | m_pidx), 15'(m_cnt)}; m_cnt = 0;
            if (ip) begin
              m_icnt++;
              if (m_stop != 0 && m_icnt == m_stop) m_mode = M_DRAIN;
            end
          end else if (CLKEN) begin
            if (m_cnt == MAXC) begin push = 1; w = 16'h7FFF; m_cnt = 0; end
            else m_cnt++;
          end
        end
        M_DRAIN: if (m_q.size() == 0) m_mode = M_DONE;
        default: ;
      endcase
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < 16) m_q.push_back(w);
        else m_ovr = 1;
      end
      m_pidx = ip;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLOCK) begin
    if (chk_en) begin
      chk("write",   WRITE,   m_q.size() != 0);
      chk("data",    DATA,    (m_q.size() != 0) ? m_q[0] : 16'h0000);
      chk("busy",    BUSY,    m_mode == M_ARM || m_mode == M_ACQ || m_mode == M_DRAIN);
      chk("done",    DONE,    m_mode == M_DONE);
      chk("overrun", OVERRUN, m_ovr);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      cyc++;
    end
    #1;
  endtask

  task automatic arm_run(input bit wi, input logic [7:0] stop);
    WAIT_INDEX = wi; INDEX_STOP_COUNT = stop; START = 1;
    tick(1);
    START = 0; WAIT_INDEX = 0; INDEX_STOP_COUNT = '0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int i = 0;
    ABORT = 0; FD_RDDATA_IN = 0; FD_INDEX_IN = 0;
    while (DONE !== 1'b1 && i < budget) begin tick(1); i++; end
    chk(tag, DONE, 1);
    chk({tag, "_busy"}, BUSY, 0);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: observed no finish, expected finish within 150000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [15:0] got[16];
    int          n, ovf_seen, ovf_cyc, writes_seen, found;

    RESET_N = 0; CLKEN = 0; START = 0; ABORT = 0; WAIT_INDEX = 0;
    INDEX_STOP_COUNT = '0; FD_RDDATA_IN = 0; FD_INDEX_IN = 0; RAM_READY = 0;
    #1;
    chk_en = 1;
    tick(2);
    chk("rst_write", WRITE, 0);
    chk("rst_data", DATA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_overrun", OVERRUN, 0);
    RESET_N = 1;
    tick(2);

    // Basic: rddata edges 100 clocks apart give 0x0063 words.
    CLKEN = 1; RAM_READY = 1;
    arm_run(0, 8'd0);
    for (int k = 0; k < 6; k++) begin
      FD_RDDATA_IN = 1;
      tick(3);
      chk("basic_write", WRITE, 1);
      if (k == 0) chk("basic_first", DATA, 16'h0001);
      else        chk("basic_word", DATA, 16'h0063);
      tick(1);
      chk("basic_pop", WRITE, 0);
      tick(46);
      FD_RDDATA_IN = 0;
      tick(50);
    end
    ABORT = 1; tick(1);
    wait_done(50, "basic_done");

    // Random traffic against the model; config is changed after START to test latching.
    for (int r = 0; r < 3; r++) begin
      arm_run(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)));
      for (int i = 0; i < 400; i++) begin
        CLKEN     = ($urandom_range(0, 3) != 0);
        RAM_READY = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 7) == 0)  FD_RDDATA_IN = ~FD_RDDATA_IN;
        if ($urandom_range(0, 15) == 0) FD_INDEX_IN  = ~FD_INDEX_IN;
        ABORT = (i == 390);
        tick(1);
      end
      CLKEN = 1; RAM_READY = 1;
      wait_done(200, "rand_done");
    end

    // Overflow: a single 0x7FFF word, then counting resumes from zero.
    arm_run(0, 8'd0);
    ovf_seen = 0; ovf_cyc = 0;
    for (int i = 0; i < 34000; i++) begin
      tick(1);
      if (WRITE === 1'b1 && DATA === 16'h7FFF) begin ovf_seen++; ovf_cyc = cyc; end
    end
    chk("ovf_count", ovf_seen, 1);
    FD_RDDATA_IN = 1;
    tick(3);
    chk("ovf_resume", DATA, 16'(cyc - ovf_cyc - 1));
    ABORT = 1; tick(1);
    wait_done(50, "ovf_done");

    // Index wait and stop count of 2.
    arm_run(1, 8'd2);
    FD_RDDATA_IN = 1; tick(3); chk("idx_pre_rd", WRITE, 0);
    FD_RDDATA_IN = 0; tick(7);
    FD_INDEX_IN = 1;  tick(3); chk("idx_arm_edge", WRITE, 0);
    FD_INDEX_IN = 0;  tick(7);
    FD_RDDATA_IN = 1; tick(3); chk("idx_rd_word", WRITE, 1); chk("idx_rd_flag", DATA[15], 0);
    FD_RDDATA_IN = 0; tick(7);
    FD_INDEX_IN = 1;  tick(3); chk("idx_1_flag", DATA[15], 1); chk("idx_1_busy", BUSY, 1);
    FD_INDEX_IN = 0;  tick(7);
    FD_INDEX_IN = 1;  tick(3); chk("idx_2_flag", DATA[15], 1);
    wait_done(20, "idx_done");

    // Backpressure: 20 edges into a 16-deep buffer with the sink stalled.
    RAM_READY = 0;
    arm_run(0, 8'd0);
    for (int k = 0; k < 20; k++) begin
      FD_RDDATA_IN = 1; tick(3);
      FD_RDDATA_IN = 0; tick(7);
    end
    chk("bp_overrun", OVERRUN, 1);
    chk("bp_write", WRITE, 1);
    RAM_READY = 1; n = 0;
    for (int i = 0; i < 40; i++) begin
      if (WRITE === 1'b1 && n < 16) begin got[n] = DATA; n++; end
      tick(1);
    end
    chk("bp_count", n, 16);
    chk("bp_word0", got[0], 16'h0001);
    for (int i = 1; i < 16; i++) chk("bp_word", got[i], 16'h0009);
    ABORT = 1; tick(1);
    wait_done(50, "bp_done");

    // Collision: rddata and index edges land exactly at the counter maximum.
    arm_run(0, 8'd0);
    found = 0;
    for (int i = 0; i < 33000 && found == 0; i++) begin
      tick(1);
      if (m_mode == M_ACQ && m_cnt == MAXC - 2) found = 1;
    end
    chk("col_setup", found, 1);
    FD_RDDATA_IN = 1; FD_INDEX_IN = 1;
    tick(3);
    chk("col_word", DATA, 16'hFFFE);
    tick(1);
    chk("col_no_ovf", WRITE, 0);
    ABORT = 1; tick(1);
    wait_done(50, "col_done");

    // Reset with five words queued.
    RAM_READY = 0;
    arm_run(0, 8'd0);
    for (int k = 0; k < 5; k++) begin
      FD_RDDATA_IN = 1; tick(3);
      FD_RDDATA_IN = 0; tick(3);
    end
    chk("rst2_queued", WRITE, 1);
    #1 RESET_N = 0;
    #1;
    chk("rst2_write", WRITE, 0);
    chk("rst2_data", DATA, 0);
    chk("rst2_busy", BUSY, 0);
    tick(2);
    RESET_N = 1; RAM_READY = 1; writes_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (WRITE !== 1'b0) writes_seen++;
    end
    chk("rst2_no_words", writes_seen, 0);
    chk("rst2_idle", BUSY, 0);
    chk("rst2_done", DONE, 0);

    tick(2);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
